// File: rtl/memory_playback.sv
// memory_playback: paced reader for the 64K x 16 sample store, one read per sample period, valid/ready output.
// Optional looping playback is compiled in by defining PLAYBACK_LOOP_EN.
module memory_playback #(
   parameter int unsigned TICK_DIV = 480
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] end_addr,
   input  logic        loop,
   output logic [15:0] mem_address,
   output logic        mem_rd,
   input  logic [15:0] mem_dataout,
   output logic [15:0] sample,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FETCH, ST_CAPTURE} state_t;

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] div_q, div_d;
   logic [15:0] end_q, end_d;
   logic [15:0] sample_q, sample_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;
   logic        overrun_q, overrun_d;
   logic        loop_active;

`ifdef PLAYBACK_LOOP_EN
   assign loop_active = loop;
`else
   logic unused_loop;
   assign unused_loop = loop;
   assign loop_active = 1'b0;
`endif

   always_comb begin
      // NOTE: every next-state signal gets its default first so no path leaves a latch behind.
      state_d   = state_q;
      addr_d    = addr_q;
      div_d     = div_q;
      end_d     = end_q;
      sample_d  = sample_q;
      valid_d   = valid_q && !sample_ready;
      done_d    = 1'b0;
      overrun_d = 1'b0;

      // The divider free-runs while playing so the sample period stays exactly TICK_DIV cycles.
      if (state_q != ST_IDLE) begin
         div_d = (div_q == TICK_LAST) ? 16'd0 : div_q + 16'd1;
      end

      case (state_q)
         ST_WAIT: begin
            if (div_q == TICK_LAST) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            sample_d  = mem_dataout;
            valid_d   = 1'b1;
            overrun_d = valid_q && !sample_ready;
            if (addr_q != end_q) begin
               addr_d  = addr_q + 16'd1;
               state_d = ST_WAIT;
            end else if (loop_active) begin
               addr_d  = 16'd0;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: ;
      endcase

      // Stop has priority over start; both abandon any capture in flight.
      if (stop) begin
         state_d   = ST_IDLE;
         addr_d    = 16'd0;
         div_d     = 16'd0;
         sample_d  = sample_q;
         valid_d   = 1'b0;
         done_d    = 1'b0;
         overrun_d = 1'b0;
      end else if (start) begin
         state_d   = ST_WAIT;
         end_d     = end_addr;
         addr_d    = 16'd0;
         div_d     = 16'd0;
         sample_d  = sample_q;
         valid_d   = 1'b0;
         done_d    = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= 16'd0;
         div_q     <= 16'd0;
         end_q     <= 16'd0;
         sample_q  <= 16'd0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q   <= state_d;
         addr_q    <= addr_d;
         div_q     <= div_d;
         end_q     <= end_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign mem_address  = addr_q;
   assign mem_rd       = (state_q == ST_FETCH) || (state_q == ST_CAPTURE);
   assign busy         = (state_q != ST_IDLE);
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign done         = done_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_memory_playback.sv
// Directed bench for memory_playback with TICK_DIV=4 and a store model returning 0x1000+addr one cycle after the address.
// Loop expectations follow PLAYBACK_LOOP_EN when it is defined for both bench and design.
module tb_memory_playback;

   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic        sample_ready = 1'b0;
   logic [15:0] end_addr = 16'd0;
   logic [15:0] mem_address;
   logic [15:0] mem_dataout = 16'd0;
   logic [15:0] sample;
   logic        mem_rd, sample_valid, busy, done, overrun;

   int checks = 0;
   int failures = 0;

   logic [15:0] seen_data[$];
   int          seen_cyc[$];
   int          first_valid, n_done, n_over, done_cyc;

   memory_playback #(.TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .end_addr(end_addr), .loop(loop), .mem_address(mem_address),
      .mem_rd(mem_rd), .mem_dataout(mem_dataout), .sample(sample),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_dataout <= 16'h1000 + mem_address;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Runs n cycles from the current cycle, recording accepted samples and pulses.
   task automatic run(input int n);
      seen_data.delete();
      seen_cyc.delete();
      first_valid = -1;
      n_done = 0;
      n_over = 0;
      done_cyc = -1;
      for (int c = 0; c < n; c++) begin
         if (sample_valid && first_valid < 0) first_valid = c;
         if (sample_valid && sample_ready) begin
            seen_data.push_back(sample);
            seen_cyc.push_back(c);
         end
         if (done) begin
            n_done++;
            done_cyc = c;
         end
         if (overrun) n_over++;
         step();
      end
   endtask

   initial begin
      #2 reset_n = 1'b0;
      step();
      step();
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", sample_valid, 1'b0);
      check("rst_addr", mem_address, 16'h0);
      check("rst_done", done, 1'b0);
      reset_n = 1'b1;
      step();

      // Basic playback, ready always high.
      end_addr = 16'd3;
      sample_ready = 1'b1;
      pulse_start();
      check("t1_busy_c0", busy, 1'b1);
      check("t1_addr_c0", mem_address, 16'h0);
      run(24);
      check("t1_count", seen_data.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < seen_data.size()) begin
            check("t1_data", seen_data[i], 16'h1000 + 16'(i));
            check("t1_cycle", seen_cyc[i], 6 + 4 * i);
         end
      end
      check("t1_first_valid", first_valid, 6);
      check("t1_done_count", n_done, 1);
      check("t1_done_cycle", done_cyc, 18);
      check("t1_overrun", n_over, 0);
      check("t1_busy_end", busy, 1'b0);

      // Downstream stalled through the second capture.
      sample_ready = 1'b0;
      pulse_start();
      run(10);
      check("t2_first_valid", first_valid, 6);
      check("t2_no_early_ovr", n_over, 0);
      check("t2_overrun", overrun, 1'b1);
      check("t2_sample", sample, 16'h1001);
      check("t2_valid", sample_valid, 1'b1);
      sample_ready = 1'b1;
      step();
      check("t2_accepted", sample_valid, 1'b0);
      check("t2_ovr_single", overrun, 1'b0);
      run(10);
      check("t2_rest_count", seen_data.size(), 2);
      if (seen_data.size() == 2) begin
         check("t2_rest_a", seen_data[0], 16'h1002);
         check("t2_rest_b", seen_data[1], 16'h1003);
      end
      check("t2_rest_ovr", n_over, 0);
      check("t2_done", n_done, 1);

      // Single-sample pass.
      end_addr = 16'd0;
      pulse_start();
      run(12);
      check("t3_count", seen_data.size(), 1);
      if (seen_data.size() == 1) check("t3_data", seen_data[0], 16'h1000);
      check("t3_done_cycle", done_cyc, 6);
      check("t3_done_count", n_done, 1);
      check("t3_busy", busy, 1'b0);

      // Loop request.
      end_addr = 16'd1;
      loop = 1'b1;
      pulse_start();
      run(20);
`ifdef PLAYBACK_LOOP_EN
      check("t4_count", seen_data.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < seen_data.size()) check("t4_data", seen_data[i], 16'h1000 + 16'(i % 2));
      end
      check("t4_no_done", n_done, 0);
      check("t4_busy", busy, 1'b1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t4_stopped", busy, 1'b0);
`else
      check("t4_count", seen_data.size(), 2);
      if (seen_data.size() == 2) check("t4_last", seen_data[1], 16'h1001);
      check("t4_done_count", n_done, 1);
      check("t4_done_cycle", done_cyc, 10);
      check("t4_busy", busy, 1'b0);
`endif
      loop = 1'b0;

      // Stop during FETCH.
      end_addr = 16'd3;
      pulse_start();
      repeat (4) step();
      check("t5_fetch_rd", mem_rd, 1'b1);
      check("t5_fetch_addr", mem_address, 16'h0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t5_rd", mem_rd, 1'b0);
      check("t5_valid", sample_valid, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_done", done, 1'b0);
      run(10);
      check("t5_no_samples", seen_data.size(), 0);
      check("t5_no_done", n_done, 0);

      // Start and stop together from IDLE.
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      check("t6_busy", busy, 1'b0);
      check("t6_rd", mem_rd, 1'b0);
      run(10);
      check("t6_no_samples", seen_data.size(), 0);

      // Restart while busy with an unconsumed sample pending.
      sample_ready = 1'b0;
      pulse_start();
      repeat (7) step();
      check("t7_pending", sample_valid, 1'b1);
      check("t7_addr_pre", mem_address, 16'h1);
      pulse_start();
      check("t7_valid_cleared", sample_valid, 1'b0);
      check("t7_busy", busy, 1'b1);
      check("t7_addr", mem_address, 16'h0);
      sample_ready = 1'b1;
      run(8);
      check("t7_first_valid", first_valid, 6);
      if (seen_data.size() > 0) check("t7_data", seen_data[0], 16'h1000);
      else check("t7_seen", seen_data.size(), 1);

      // Asynchronous reset during CAPTURE.
      sample_ready = 1'b0;
      pulse_start();
      repeat (9) step();
      check("t8_pre_rd", mem_rd, 1'b1);
      check("t8_pre_valid", sample_valid, 1'b1);
      reset_n = 1'b0;
      #1;
      check("t8_addr", mem_address, 16'h0);
      check("t8_rd", mem_rd, 1'b0);
      check("t8_sample", sample, 16'h0);
      check("t8_valid", sample_valid, 1'b0);
      check("t8_busy", busy, 1'b0);
      check("t8_done", done, 1'b0);
      check("t8_overrun", overrun, 1'b0);
      #2 reset_n = 1'b1;
      step();
      sample_ready = 1'b1;
      pulse_start();
      check("t8_restart_addr", mem_address, 16'h0);
      run(8);
      check("t8_restart_first", first_valid, 6);
      if (seen_data.size() > 0) check("t8_restart_data", seen_data[0], 16'h1000);
      else check("t8_restart_seen", seen_data.size(), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_playback.md
# memory_playback

Playback reader for the 64K x 16 sample store. On `start` it walks addresses 0..`end_addr`, issuing one read per sample period. Each read honours the store's one-cycle registered read latency, and the returned word is presented downstream on a valid/ready interface. It sits between the sample store's address/data mux and the audio output path: it is the read-side counterpart of the recording writer.

## Interface
Parameters:
- `TICK_DIV`, default 480: clock cycles per sample period (48 MHz / 100 kHz). Legal range 4..65535.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begin playback from address 0.
- `stop`  in  1  one-cycle pulse; abort playback.
- `end_addr`  in  16  last address to play, inclusive; latched on `start`.
- `loop`  in  1  wrap to address 0 after `end_addr` (see Configuration).
- `mem_address`  out  16  read address to the sample store.
- `mem_rd`  out  1  high while this block owns the store address bus.
- `mem_dataout`  in  16  read data from the store, valid one cycle after the address is clocked.
- `sample`  out  16  output sample.
- `sample_valid`  out  1  `sample` holds unconsumed data.
- `sample_ready`  in  1  downstream accepts `sample` when high together with `sample_valid`.
- `busy`  out  1  playback in progress.
- `done`  out  1  one-cycle pulse when the `end_addr` sample is captured in non-loop mode.
- `overrun`  out  1  one-cycle pulse when a captured sample overwrites an unconsumed one.

## Operation
- Reset values: state IDLE, addr 0, divider 0, latched end 0. All outputs 0.
- IDLE: `mem_rd`=0 and `busy`=0. `start` does the following:
  - latches `end_addr`;
  - sets addr to 0 and divider to 0;
  - goes to WAIT with `busy`=1.
- WAIT: the divider counts 0..`TICK_DIV`-1 and then wraps. The tick fires when divider = `TICK_DIV`-1, and the state moves to FETCH.
- FETCH: `mem_rd`=1 and `mem_address`=addr. The store clocks the address at the end of this cycle. Go to CAPTURE.
- CAPTURE:
  - `mem_rd`=1 and addr is held, so the store's output mux stays selected.
  - `mem_dataout` is loaded into `sample` and `sample_valid` is set.
  - If `sample_valid` was already 1 and not being consumed this cycle, `overrun` pulses and the old sample is lost.
  - If addr ≠ latched end: addr increments and the state returns to WAIT.
  - If addr = latched end and loop is active: addr goes to 0 and the state returns to WAIT.
  - Otherwise: the state goes to IDLE, `done` pulses and `busy` drops.
- The divider runs continuously through WAIT, FETCH and CAPTURE, so the sample period is exactly `TICK_DIV` cycles.
- Handshake:
  - `sample_valid` clears on the cycle after `sample_valid && sample_ready`.
  - `sample` is stable while valid and unaccepted, except for an overrun overwrite.
  - Consumption in the same cycle as a CAPTURE counts as accepted: no overrun, and the new sample is loaded.
- `stop` (any state): next state IDLE, `busy`=0 and `sample_valid`=0. No `done` pulse. `mem_rd` drops next cycle.
- `start` while busy: restarts from address 0 and re-latches `end_addr`. `sample_valid` is cleared.
- `start` and `stop` in the same cycle: `stop` wins.
- `end_addr`=0 plays exactly one sample per pass.
- Address arithmetic is 16-bit. Wrap only through the end/loop rule; 0xFFFF → 0 occurs only when the latched end is 0xFFFF.

## Timing
- `start` at edge E0: `busy`=1 after E0 and the divider is 0.
- First tick is in cycle `TICK_DIV`-1 after E0. FETCH is the next cycle, then CAPTURE, and `sample_valid` rises one cycle after CAPTURE.
- Tick → `sample_valid` latency is 3 cycles. One sample every `TICK_DIV` cycles.
- `mem_address` is registered and changes only on the CAPTURE→WAIT transition, or on start/stop.
- `done` and `overrun` are registered and high for exactly one cycle.
- Reset asserted mid-playback forces all outputs to 0 immediately (asynchronously).

## Configuration
- `PLAYBACK_LOOP_EN`:
  - Defined: `loop`=1 wraps addr to 0 after the `end_addr` sample and `done` never pulses.
  - Undefined: `loop` is ignored. Playback always ends after `end_addr`, with `done` pulsed and the port left unused.

## Test plan
- `TICK_DIV`=4, `end_addr`=3, store preloaded 0x1000+addr, `sample_ready`=1. Required:
  - samples 0x1000..0x1003, spaced 4 cycles apart;
  - first `sample_valid` 6 cycles after `start`;
  - `done` pulses once, `busy`=0 afterward.
- Same setup with `sample_ready`=0 until after the second capture. Required: `overrun` pulses once and `sample`=0x1001 when finally accepted.
- `end_addr`=0x0000. Required: exactly one sample 0x1000, `done` after the first CAPTURE.
- With `PLAYBACK_LOOP_EN`, `loop`=1, `end_addr`=1. Required: sequence 0x1000, 0x1001, 0x1000, 0x1001…; `done` never asserts.
- Timing of `stop` and `start`:
  - `stop` during FETCH: next cycle `mem_rd`=0, `sample_valid`=0, `busy`=0, no `done`.
  - `start` and `stop` together: state remains IDLE.
- Reset: assert `reset_n`=0 mid-CAPTURE. Required: all outputs 0 immediately. After release and `start`, playback begins at address 0.
